// File: rtl/adder_arbiter_pkg.sv
// adder_arb_pkg: shared types and helpers for the adder_arbiter block.
//   state_t  - sequencer states (IDLE, RUN, DONE)
//   cnt_w()  - chunk-counter width, $clog2(chunks) but never below 1 bit
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request, response and shared-adder signals of the
// adder_arbiter block.
//   req_valid/req_ready/req_a/req_b/req_cin : per-requester wide add requests,
//                                             requester i at [i*WIDE +: WIDE]
//   rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout/rsp_ovf : result channel
//   add_a/add_b/add_cin -> adder, add_sum/add_cout <- adder (combinational)
// Modports: slave = the arbiter, master = clients plus the adder instance.
interface adder_arbiter_if #(
  parameter int NUM_REQ   = 3,
  parameter int BIT_WIDTH = 4,
  parameter int CHUNKS    = 4
);
  localparam int WIDE = CHUNKS * BIT_WIDTH;
  localparam int IDW  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*WIDE-1:0] req_a;
  logic [NUM_REQ*WIDE-1:0] req_b;
  logic [NUM_REQ-1:0]      req_cin;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [WIDE-1:0]         rsp_sum;
  logic                    rsp_cout;
  logic                    rsp_ovf;

  logic [BIT_WIDTH-1:0]    add_a;
  logic [BIT_WIDTH-1:0]    add_b;
  logic                    add_cin;
  logic [BIT_WIDTH-1:0]    add_sum;
  logic                    add_cout;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready, add_sum, add_cout,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
           add_a, add_b, add_cin
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready, add_sum, add_cout,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
           add_a, add_b, add_cin
  );

endinterface

// File: rtl/adder_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req_i  - request vector
//   ptr_i  - highest-priority index this cycle
//   en_i   - grant allowed
//   gnt_o  - one-hot grant (zero when disabled or no request)
//   id_o   - encoded grant index (0 when no grant)
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     id_o
);

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    gnt_o = '0;
    id_o  = '0;
    if (en_i) begin
      // Scan ptr, ptr+1, ... wrapping; first requester seen wins.
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr_i) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          id_o       = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one BIT_WIDTH adder between NUM_REQ requesters.
// Each accepted request is a CHUNKS*BIT_WIDTH add, sequenced LSB chunk first
// with the carry chained through a register; the result is held until the
// consumer takes it.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : adder_arbiter_if.slave (requests, response, adder hookup)
// Optional: define ADDER_ARB_SIGNED_OVF_EN to produce a signed-overflow flag
// on rsp_ovf; otherwise rsp_ovf is tied low.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int CHUNKS    = 4,
  parameter int NUM_REQ   = 3
) (
  input  logic            clk,
  input  logic            rst,
  adder_arbiter_if.slave  bus
);

  localparam int WIDE = CHUNKS * BIT_WIDTH;
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CW   = cnt_w(CHUNKS);

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic [WIDE-1:0] a_q, b_q, res_q;
  logic            cin_q;
  logic [IDW-1:0]  id_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               run;

  // Gating with rst keeps req_ready low while reset is held even though
  // the grant path is combinational.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  ((state_q == IDLE) && !rst),
    .gnt_o (gnt),
    .id_o  (gnt_id)
  );

  assign run           = (state_q == RUN);
  assign bus.req_ready = gnt;
  assign bus.add_a     = run ? a_q[cnt_q*BIT_WIDTH +: BIT_WIDTH] : '0;
  assign bus.add_b     = run ? b_q[cnt_q*BIT_WIDTH +: BIT_WIDTH] : '0;
  assign bus.add_cin   = run && ((cnt_q == '0) ? cin_q : carry_q);

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = res_q;
  assign bus.rsp_cout  = carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cin_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (|gnt) begin
          a_q     <= bus.req_a[gnt_id*WIDE +: WIDE];
          b_q     <= bus.req_b[gnt_id*WIDE +: WIDE];
          cin_q   <= bus.req_cin[gnt_id];
          id_q    <= gnt_id;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          res_q[cnt_q*BIT_WIDTH +: BIT_WIDTH] <= bus.add_sum;
          carry_q <= bus.add_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(CHUNKS - 1)) state_q <= DONE;
        end
        DONE: if (bus.rsp_ready) begin
          state_q  <= IDLE;
          rr_ptr_q <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ADDER_ARB_SIGNED_OVF_EN
  logic ovf_q;

  // Sampled on the last chunk, whose adder sum carries the wide sign bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (run && (cnt_q == CW'(CHUNKS - 1))) begin
      ovf_q <= (a_q[WIDE-1] == b_q[WIDE-1]) &&
               (bus.add_sum[BIT_WIDTH-1] != a_q[WIDE-1]);
    end
  end

  assign bus.rsp_ovf = ovf_q;
`else
  assign bus.rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  localparam int BW   = 4;
  localparam int CH   = 4;
  localparam int NR   = 3;
  localparam int WIDE = BW * CH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_arbiter_if #(.NUM_REQ(NR), .BIT_WIDTH(BW), .CHUNKS(CH)) bus ();

  adder_arbiter #(.BIT_WIDTH(BW), .CHUNKS(CH), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The shared adder instance.
  assign {bus.add_cout, bus.add_sum} =
    {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{BW{1'b0}}, bus.add_cin};

  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;   // reference round-robin pointer

  logic [WIDE-1:0] op_a [NR];
  logic [WIDE-1:0] op_b [NR];
  logic            op_c [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops(input logic [NR-1:0] vld);
    bus.req_valid = vld;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*WIDE +: WIDE] = op_a[i];
      bus.req_b[i*WIDE +: WIDE] = op_b[i];
      bus.req_cin[i]            = op_c[i];
    end
  endtask

  function automatic int exp_grant(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
    return 0;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      op_a[i] = WIDE'($urandom());
      op_b[i] = WIDE'($urandom());
      op_c[i] = 1'($urandom());
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_sum"},   bus.rsp_sum,   0);
    chk({tag, "_rsp_id"},    bus.rsp_id,    0);
    chk({tag, "_rsp_cout"},  bus.rsp_cout,  0);
    chk({tag, "_rsp_ovf"},   bus.rsp_ovf,   0);
    chk({tag, "_add_a"},     bus.add_a,     0);
    chk({tag, "_add_b"},     bus.add_b,     0);
    chk({tag, "_add_cin"},   bus.add_cin,   0);
  endtask

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 idle again.
  task automatic run_op(input logic [NR-1:0] vld, input int stall);
    int              g;
    logic [NR-1:0]   oh;
    logic [WIDE:0]   full;
    logic            eovf;
    drive_ops(vld);
    g = exp_grant(vld);
    oh = '0;
    oh[g] = 1'b1;
    full = {1'b0, op_a[g]} + {1'b0, op_b[g]} + {{WIDE{1'b0}}, op_c[g]};
`ifdef ADDER_ARB_SIGNED_OVF_EN
    eovf = (op_a[g][WIDE-1] == op_b[g][WIDE-1]) && (full[WIDE-1] != op_a[g][WIDE-1]);
`else
    eovf = 1'b0;
`endif
    #1 chk("grant", bus.req_ready, oh);
    @(posedge clk); #1;
    // Requesters keep asserting valid; operands change and must be ignored.
    bus.req_a   = 48'({$urandom(), $urandom()});
    bus.req_b   = 48'({$urandom(), $urandom()});
    bus.req_cin = 3'($urandom());
    for (int c = 0; c < CH; c++) begin
      #1;
      chk("run_rsp_valid", bus.rsp_valid, 0);
      chk("run_req_ready", bus.req_ready, 0);
      @(posedge clk); #1;
    end
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) bus.rsp_ready = 1'b1;
      #1;
      chk("done_valid", bus.rsp_valid, 1);
      chk("done_sum",   bus.rsp_sum,   full[WIDE-1:0]);
      chk("done_cout",  bus.rsp_cout,  full[WIDE]);
      chk("done_id",    bus.rsp_id,    g);
      chk("done_ovf",   bus.rsp_ovf,   eovf);
      chk("done_req_ready", bus.req_ready, 0);
      chk("done_add_a", bus.add_a, 0);
      @(posedge clk); #1;
    end
    chk("back_idle", bus.rsp_valid, 0);
    bus.rsp_ready = 1'b0;
    ptr_m = (g + 1) % NR;
  endtask

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    rand_ops();
    drive_ops(3'b111);   // valid held through reset must not be granted
    repeat (2) @(posedge clk);
    #1 chk_zero_outputs("reset");
    rst = 1'b0;
    ptr_m = 0;

    // All requesters held: served 0,1,2,0.
    for (int n = 0; n < 4; n++) begin
      rand_ops();
      run_op(3'b111, 0);
    end

    // No request: nothing granted.
    drive_ops(3'b000);
    #1 chk("idle_no_req", bus.req_ready, 0);
    @(posedge clk); #1;
    chk("idle_stays", bus.rsp_valid, 0);

    // Directed carry cases.
    op_a[0] = 16'h00FF; op_b[0] = 16'h0001; op_c[0] = 1'b0;
    run_op(3'b001, 0);
    op_a[1] = 16'hFFFF; op_b[1] = 16'h0000; op_c[1] = 1'b1;
    run_op(3'b010, 3);
    op_a[2] = 16'h7FFF; op_b[2] = 16'h0001; op_c[2] = 1'b0;
    run_op(3'b100, 1);

    // Move the pointer to 2, then abort an op with reset during chunk 2.
    rand_ops();
    run_op(3'b010, 0);
    drive_ops(3'b001);
    @(posedge clk); #1;      // accepted, chunk 0
    @(posedge clk); #1;      // chunk 1
    @(posedge clk); #1;      // chunk 2
    rst = 1'b1;
    #1 chk_zero_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    ptr_m = 0;
    bus.req_valid = '0;
    run_op(3'b110, 0);       // pointer back at 0 -> requester 1 wins
    rand_ops();
    run_op(3'b100, 0);

    // Randomized traffic.
    for (int n = 0; n < 20; n++) begin
      rand_ops();
      run_op(3'($urandom_range(1, 7)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one BIT_WIDTH ripple adder (sum/overflow datapath, overflow = carry-out) between NUM_REQ requesters.
- Each requester submits a wide add of CHUNKS*BIT_WIDTH bits. The block arbitrates round-robin and sequences the add chunk by chunk, LSB first, chaining carry through a register.
- Sits between client request ports and the single adder instance.

Parameters:
- BIT_WIDTH, 4: adder width, bits per chunk.
- CHUNKS, 4: chunks per operation; WIDE = CHUNKS*BIT_WIDTH.
- NUM_REQ, 3: number of requesters (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*WIDE  operand A, requester i at [i*WIDE +: WIDE]
- req_b  in  NUM_REQ*WIDE  operand B, same packing
- req_cin  in  NUM_REQ  carry-in per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  $clog2(NUM_REQ)  index of the requester served
- rsp_sum  out  WIDE  wide sum
- rsp_cout  out  1  final carry-out
- rsp_ovf  out  1  signed overflow (see Optional Feature)
- add_a  out  BIT_WIDTH  to adder a
- add_b  out  BIT_WIDTH  to adder b
- add_cin  out  1  to adder carry_in
- add_sum  in  BIT_WIDTH  from adder sum (combinational, same cycle)
- add_cout  in  1  from adder overflow (carry-out)

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, chunk_cnt=0, carry=0. Operand/result regs are 0. Every output is 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req_valid, pick a grant by round-robin starting at rr_ptr.
  - Assert req_ready[grant] combinationally in the same cycle; handshake completes that cycle.
  - Latch operands, cin and grant id. Set chunk_cnt=0. Go to RUN.
  - req_ready is 0 in every other state and when no req_valid.
- RUN (exactly CHUNKS cycles):
  - add_a/add_b = chunk chunk_cnt of the latched operands.
  - add_cin = latched cin when chunk_cnt=0, else the carry reg.
  - Each cycle: result chunk chunk_cnt <= add_sum; carry <= add_cout; chunk_cnt++.
  - After chunk CHUNKS-1, go to DONE.
- Outside RUN, add_a/add_b/add_cin = 0.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout(=carry), rsp_id and rsp_ovf held stable.
  - On rsp_ready: go to IDLE and set rr_ptr = (grant+1) mod NUM_REQ.
  - Backpressure is unlimited; no new request is accepted while in DONE.
- Latency: accept in cycle T gives rsp_valid first high at T+CHUNKS+1. Peak throughput is one op per CHUNKS+2 cycles.
- Round-robin: after serving i, priority order is i+1, i+2, ..., wrapping. A requester that drops req_valid before grant loses nothing.
- Requester inputs are ignored outside IDLE; operands must be stable only in the handshake cycle.
- chunk_cnt width is $clog2(CHUNKS) with a minimum of 1. Sum wraps mod 2^WIDE; the carry goes to rsp_cout.

Optional Feature:
- Macro: ADDER_ARB_SIGNED_OVF_EN.
- Defined: rsp_ovf = (a_msb == b_msb) && (sum_msb != a_msb), using the latched wide operands and result. Registered with the last chunk; valid in DONE.
- Not defined: rsp_ovf tied to 0. The port list is unchanged.

Decomposition:
- Package adder_arb_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - Chunk-counter width helper function.
- Sub-module rr_arbiter(NUM_REQ): inputs req vector, rr_ptr, enable; outputs one-hot grant and encoded id. Combinational, instantiated once.

Test Plan (BIT_WIDTH=4, CHUNKS=4, NUM_REQ=3):
- req0 a=0x00FF b=0x0001 cin=0 -> req_ready[0] in cycle T; rsp_valid at T+5; rsp_sum=0x0100, cout=0, id=0.
- req1 a=0xFFFF b=0x0000 cin=1 -> rsp_sum=0x0000, cout=1, id=1; carry ripples through all 4 chunks.
- All three req_valid held from reset, rsp_ready=1 -> served ids 0,1,2,0; req_ready is never multi-hot.
- rsp_ready low 3 cycles in DONE -> rsp_* stable, req_ready stays 0; release -> IDLE next cycle.
- rst asserted during RUN chunk 2 -> all outputs 0 immediately; rr_ptr=0; after release, req2-only is served correctly.
- a=0x7FFF b=0x0001 -> sum=0x8000; rsp_ovf=1 with ADDER_ARB_SIGNED_OVF_EN, 0 without.
